uart_tx_arbiter: RTL and testbench

//  Shares one CoreUARTapb transmitter (no-FIFO build) among NUM_REQ byte sources.
//  - Round-robin grant per packet; the grant is held until the byte flagged req_last is accepted.
//  - Writes each byte to the UART holding register, then tracks the UART's txrdy handshake.
//  - Sits between the requester logic and the UART's APB-side holding-register write path.

---
 rtl/uart_tx_arb_pkg.sv | 21 ++
 rtl/uart_rr_arbiter.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_e : arbiter FSM states (TAG is only reachable when UART_TX_ARB_TAG_EN is defined)
//   TAG_NIBBLE  : upper nibble of the per-packet tag byte
//   ack_cnt_w() : width of the write-acknowledge timeout counter
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        ARB      = 2'd0,
        TAG      = 2'd1,
        SEND     = 2'd2,
        WAIT_ACK = 2'd3
    } arb_state_e;

    localparam logic [3:0] TAG_NIBBLE = 4'hA;

    // The counter must be able to hold the value ACK_TIMEOUT itself.
    function automatic int ack_cnt_w(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin select.
//   i_valid : request vector
//   i_ptr   : highest-priority index for this decision
//   o_gnt   : first valid index at or after i_ptr, wrapping at NUM_REQ-1
//   o_any   : at least one request is valid
module uart_rr_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDW-1:0]     i_ptr,
    output logic [IDW-1:0]     o_gnt,
    output logic               o_any
);

    int                 w_idx;
    logic [NUM_REQ-1:0] w_sh;

    always_comb begin
        o_gnt = '0;
        o_any = 1'b0;
        w_idx = 0;
        w_sh  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            // Shift rather than index so the select is width-clean for any NUM_REQ.
            w_sh = i_valid >> w_idx;
            if (!o_any && w_sh[0]) begin
                o_any = 1'b1;
                o_gnt = IDW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one no-FIFO UART transmitter among NUM_REQ byte sources.
// Round-robin grant per packet, held until the byte flagged req_last is accepted.
// Each byte is written to the holding register, then the txrdy fall is awaited.
// Optional feature macro: UART_TX_ARB_TAG_EN -- prefixes each packet with the tag
// byte {4'hA, grant_id}.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   req_valid   : per-requester byte valid        req_data : byte i at [8i+7:8i]
//   req_last    : per-requester end of packet     req_ready: byte i accepted this cycle
//   uart_txrdy  : UART holding register empty
//   uart_wr     : one-cycle write strobe          uart_wdata : byte written
//   grant_id    : current/last grant              busy : FSM not in ARB
//   ack_err     : sticky, txrdy never dropped after a write
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int IDW         = 2,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 uart_txrdy,
    output logic                 uart_wr,
    output logic [7:0]           uart_wdata,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic                 ack_err
);

    localparam int CW = ack_cnt_w(ACK_TIMEOUT);

    arb_state_e         r_state, w_next;
    logic [IDW-1:0]     r_ptr, r_grant, w_gnt;
    logic               w_any;
    logic               r_wr, r_last, r_ack_err;
    logic [7:0]         r_wdata;
    logic [CW-1:0]      r_cnt;
    logic [NUM_REQ-1:0] w_ready;
    logic               w_sel_valid, w_sel_last;
    logic [7:0]         w_sel_data;
    logic               w_accept, w_tag_wr, w_grant_load, w_tmo;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_any   (w_any)
    );

    // Mux out the granted requester's lane.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == IDW'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
                w_sel_data  = req_data[8*i +: 8];
            end
        end
    end

    assign w_tmo = (r_cnt == CW'(ACK_TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ARB;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_ready      = '0;
        w_accept     = 1'b0;
        w_tag_wr     = 1'b0;
        w_grant_load = 1'b0;
        case (r_state)
            ARB: begin
                if (w_any) begin
                    w_grant_load = 1'b1;
`ifdef UART_TX_ARB_TAG_EN
                    w_next = TAG;
`else
                    w_next = SEND;
`endif
                end
            end
            TAG: begin
`ifdef UART_TX_ARB_TAG_EN
                if (uart_txrdy) begin
                    w_tag_wr = 1'b1;
                    w_next   = WAIT_ACK;
                end
`else
                w_next = ARB;
`endif
            end
            SEND: begin
                // Valid dropping mid-packet simply parks here; the grant is not released.
                w_accept = uart_txrdy & w_sel_valid;
                for (int i = 0; i < NUM_REQ; i++)
                    w_ready[i] = w_accept && (r_grant == IDW'(i));
                if (w_accept) w_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                // A timeout is handled exactly like a real acknowledge.
                if (!uart_txrdy || w_tmo) w_next = r_last ? ARB : SEND;
            end
            default: w_next = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr     <= '0;
            r_grant   <= '0;
            r_wr      <= 1'b0;
            r_wdata   <= '0;
            r_last    <= 1'b0;
            r_cnt     <= '0;
            r_ack_err <= 1'b0;
        end else begin
            r_wr <= w_accept | w_tag_wr;
            if (w_grant_load) begin
                r_grant <= w_gnt;
                r_ptr   <= (int'(w_gnt) == NUM_REQ - 1) ? '0 : w_gnt + 1'b1;
            end
            if (w_accept) begin
                r_wdata <= w_sel_data;
                r_last  <= w_sel_last;
            end else if (w_tag_wr) begin
                // The tag never ends a packet, so its acknowledge returns to SEND.
                r_wdata <= {TAG_NIBBLE, 4'(r_grant)};
                r_last  <= 1'b0;
            end
            r_cnt <= (r_state == WAIT_ACK) ? r_cnt + 1'b1 : '0;
            if (r_state == WAIT_ACK && w_tmo && uart_txrdy) r_ack_err <= 1'b1;
        end
    end

    assign req_ready  = w_ready;
    assign uart_wr    = r_wr;
    assign uart_wdata = r_wdata;
    assign grant_id   = r_grant;
    assign busy       = (r_state != ARB);
    assign ack_err    = r_ack_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-requester byte queues drive the
// inputs, a UART model drops txrdy one clock after each write and raises it ten
// clocks later, and a packet-level round-robin model predicts the written stream.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int TMO = 15;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic           uart_txrdy, uart_wr, busy, ack_err;
    logic [7:0]     uart_wdata;
    logic [1:0]     grant_id;

    int total = 0;
    int bad   = 0;

    // queue entry: {first, last, data}
    logic [9:0] srcq [N][$];
    logic [9:0] mq   [N][$];
    logic [7:0] wq[$], exp_d[$];
    logic [1:0] gq[$], exp_g[$];
    int         acc_log[$];       // id*2 + last, in acceptance order
    bit         stall_en = 0;
    bit         no_ack   = 0;
    logic [N-1:0] hold   = '0;
    int         proto_err = 0;
    int         m_ptr     = 0;

    uart_tx_arbiter #(.NUM_REQ(N), .IDW(2), .ACK_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .uart_txrdy (uart_txrdy),
        .uart_wr    (uart_wr),
        .uart_wdata (uart_wdata),
        .grant_id   (grant_id),
        .busy       (busy),
        .ack_err    (ack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sources, write monitor and handshake protocol checks.
    initial begin : src
        logic [N-1:0] hs;
        logic [N-1:0] stall;
        req_valid = '0; req_data = '0; req_last = '0;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            if ((req_ready & ~(4'b0001 << grant_id)) != '0) proto_err++;
            if (req_ready != '0 && busy !== 1'b1) proto_err++;
            if (uart_wr === 1'b1) begin
                wq.push_back(uart_wdata);
                gq.push_back(grant_id);
                if (uart_txrdy !== 1'b1) proto_err++;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                stall[i] = hold[i] | (stall_en && ($urandom_range(0, 2) == 0));
                if (hs[i] && srcq[i].size() > 0) begin
                    acc_log.push_back(i * 2 + int'(srcq[i][0][8]));
                    void'(srcq[i].pop_front());
                end
                // Only bytes inside a packet are stalled, so arbitration stays predictable.
                if (srcq[i].size() > 0 && !(stall[i] && !srcq[i][0][9])) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = srcq[i][0][7:0];
                    req_last[i]        = srcq[i][0][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'($urandom);
                    req_last[i]        = 1'($urandom);
                end
            end
        end
    end

    // UART holding register model.
    initial begin : uart
        uart_txrdy = 1'b1;
        forever begin
            @(negedge clk);
            if (uart_wr === 1'b1 && !no_ack) begin
                @(posedge clk);
                #1 uart_txrdy = 1'b0;
                repeat (10) @(posedge clk);
                #1 uart_txrdy = 1'b1;
            end
        end
    end

    task automatic push_byte(input int id, input logic [7:0] d, input bit first, input bit last);
        srcq[id].push_back({first, last, d});
        mq[id].push_back({first, last, d});
    endtask

    // Packet-level reference: rotate over requesters that still hold packets.
    task automatic model_expect();
        int idx;
        logic [9:0] e;
        exp_d.delete(); exp_g.delete();
        while (1) begin
            idx = -1;
            for (int k = 0; k < N; k++)
                if (idx < 0 && mq[(m_ptr + k) % N].size() > 0) idx = (m_ptr + k) % N;
            if (idx < 0) break;
            m_ptr = (idx + 1) % N;
`ifdef UART_TX_ARB_TAG_EN
            exp_d.push_back(8'hA0 | 8'(idx));
            exp_g.push_back(2'(idx));
`endif
            do begin
                e = mq[idx].pop_front();
                exp_d.push_back(e[7:0]);
                exp_g.push_back(2'(idx));
            end while (!e[8]);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            mq[i].delete();
        end
        stall_en = 0; hold = '0; no_ack = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_all();
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        m_ptr = 0;
        for (int c = 0; c < 20 && uart_txrdy !== 1'b1; c++) @(posedge clk);
        #2;
        wq.delete(); gq.delete(); acc_log.delete();
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int pend;
        ok = 0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            pend = 0;
            for (int i = 0; i < N; i++) pend += srcq[i].size();
            if (pend == 0 && busy === 1'b0 && uart_txrdy === 1'b1) ok = 1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 push_byte(0, 8'hEE, 1, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({uart_wr, uart_wdata, grant_id, ack_err, busy, req_ready} !== 16'h0) begin
            bad++;
            $display("FAIL reset outputs: wr=%b wdata=%h gnt=%0d err=%b busy=%b rdy=%b, want all 0",
                     uart_wr, uart_wdata, grant_id, ack_err, busy, req_ready);
        end
        clear_all();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (busy !== 1'b0 || uart_wr !== 1'b0) begin
            bad++;
            $display("FAIL idle after reset: busy=%b wr=%b want 0/0", busy, uart_wr);
        end
    endtask

    task automatic test_single_packet();
        bit ok;
        do_reset();
        push_byte(1, 8'h11, 1, 0);
        push_byte(1, 8'h22, 0, 0);
        push_byte(1, 8'h33, 0, 1);
        model_expect();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL t1 busy during packet: got %b want 1", busy); end
        wait_idle(300, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL t1 idle timeout: busy=%b want 0", busy); end
        total++;
        if (wq.size() != exp_d.size()) begin
            bad++; $display("FAIL t1 write count: got %0d want %0d", wq.size(), exp_d.size());
        end
        for (int k = 0; k < wq.size() && k < exp_d.size(); k++) begin
            total++;
            if (wq[k] !== exp_d[k] || gq[k] !== exp_g[k]) begin
                bad++;
                $display("FAIL t1 write %0d: got %h id%0d want %h id%0d", k, wq[k], gq[k], exp_d[k], exp_g[k]);
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push_byte(i, 8'(8'h40 + 16 * i + r), 1, 1);
        model_expect();
        wait_idle(800, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL t2 idle timeout: busy=%b want 0", busy); end
        total++;
        if (wq.size() != exp_d.size()) begin
            bad++; $display("FAIL t2 write count: got %0d want %0d", wq.size(), exp_d.size());
        end
        for (int k = 0; k < wq.size() && k < exp_d.size(); k++) begin
            total++;
            if (wq[k] !== exp_d[k] || gq[k] !== exp_g[k]) begin
                bad++;
                $display("FAIL t2 write %0d: got %h id%0d want %h id%0d", k, wq[k], gq[k], exp_d[k], exp_g[k]);
            end
        end
    endtask

    task automatic test_hold();
        bit ok;
        int pos_last0, pos_2;
        do_reset();
        hold[0] = 1'b1;
        push_byte(0, 8'hA0, 1, 0);
        push_byte(0, 8'hA1, 0, 0);
        push_byte(0, 8'hA2, 0, 0);
        push_byte(0, 8'hA3, 0, 1);
        push_byte(2, 8'hC2, 1, 1);
        model_expect();
        repeat (60) @(posedge clk);
        @(negedge clk);
        total++;
`ifdef UART_TX_ARB_TAG_EN
        if (wq.size() != 2) begin bad++; $display("FAIL t3 writes while held: got %0d want 2", wq.size()); end
`else
        if (wq.size() != 1) begin bad++; $display("FAIL t3 writes while held: got %0d want 1", wq.size()); end
`endif
        #1 hold[0] = 1'b0;
        wait_idle(600, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL t3 idle timeout: busy=%b want 0", busy); end
        pos_last0 = -1; pos_2 = -1;
        foreach (acc_log[k]) begin
            if (acc_log[k] == 1) pos_last0 = k;
            if (acc_log[k] == 5) pos_2 = k;
        end
        total++;
        if (pos_last0 < 0 || pos_2 <= pos_last0) begin
            bad++; $display("FAIL t3 accept order: req0 last at %0d, req2 at %0d, want req2 after", pos_last0, pos_2);
        end
        total++;
        if (wq.size() != exp_d.size()) begin
            bad++; $display("FAIL t3 write count: got %0d want %0d", wq.size(), exp_d.size());
        end
        for (int k = 0; k < wq.size() && k < exp_d.size(); k++) begin
            total++;
            if (wq[k] !== exp_d[k] || gq[k] !== exp_g[k]) begin
                bad++;
                $display("FAIL t3 write %0d: got %h id%0d want %h id%0d", k, wq[k], gq[k], exp_d[k], exp_g[k]);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok, found, seen;
        int dly;
        do_reset();
        no_ack = 1;
        push_byte(0, 8'h77, 1, 1);
        model_expect();
        found = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            if (uart_wr === 1'b1) found = 1;
        end
        total++;
        if (!found || ack_err !== 1'b0) begin
            bad++; $display("FAIL t4 first write: seen=%b err=%b want 1/0", found, ack_err);
        end
        seen = 0; dly = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (ack_err === 1'b1) begin seen = 1; dly = c; end
        end
        total++;
        if (!seen || dly < TMO || dly > TMO + 2) begin
            bad++; $display("FAIL t4 ack_err delay: got %0d (seen=%b) want %0d..%0d", dly, seen, TMO, TMO + 2);
        end
        wait_idle(200, ok);
        total++;
        if (!ok || ack_err !== 1'b1) begin
            bad++; $display("FAIL t4 continue after timeout: idle=%b err=%b want 1/1", ok, ack_err);
        end
        total++;
        if (wq.size() != exp_d.size() || wq[wq.size()-1] !== 8'h77) begin
            bad++; $display("FAIL t4 timed-out stream: got %0d writes want %0d ending 77", wq.size(), exp_d.size());
        end
        no_ack = 0;
        wq.delete(); gq.delete();
        push_byte(1, 8'h99, 1, 1);
        model_expect();
        wait_idle(200, ok);
        total++;
        if (!ok || wq.size() != exp_d.size() || ack_err !== 1'b1) begin
            bad++; $display("FAIL t4 after timeout: idle=%b writes=%0d want %0d err=%b want 1",
                            ok, wq.size(), exp_d.size(), ack_err);
        end
        do_reset();
        @(negedge clk);
        total++;
        if (ack_err !== 1'b0) begin bad++; $display("FAIL t4 ack_err after reset: got %b want 0", ack_err); end
    endtask

    task automatic test_single_byte_tag();
        bit ok;
        int n3;
        do_reset();
        push_byte(3, 8'h5A, 1, 1);
        model_expect();
        wait_idle(200, ok);
        n3 = 0;
        foreach (acc_log[k]) if (acc_log[k] / 2 == 3) n3++;
        total++;
        if (!ok || n3 != 1) begin bad++; $display("FAIL t5 req_ready[3] pulses: got %0d want 1 (idle=%b)", n3, ok); end
        total++;
        if (wq.size() != exp_d.size()) begin
            bad++; $display("FAIL t5 write count: got %0d want %0d", wq.size(), exp_d.size());
        end
        for (int k = 0; k < wq.size() && k < exp_d.size(); k++) begin
            total++;
            if (wq[k] !== exp_d[k] || gq[k] !== exp_g[k]) begin
                bad++;
                $display("FAIL t5 write %0d: got %h id%0d want %h id%0d", k, wq[k], gq[k], exp_d[k], exp_g[k]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        bit ok, found;
        int nw;
        do_reset();
        hold[1] = 1'b1;
        push_byte(1, 8'h01, 1, 0);
        push_byte(1, 8'h02, 0, 1);
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (wq.size() > 0 && wq[wq.size()-1] === 8'h01) found = 1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL t6 first byte not written within budget"); end
        #1 hold[1] = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        nw = wq.size();
        @(negedge clk);
        total++;
        if (uart_wr !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0 || req_ready !== '0) begin
            bad++; $display("FAIL t6 reset mid packet: wr=%b busy=%b gnt=%0d rdy=%b want 0/0/0/0",
                            uart_wr, busy, grant_id, req_ready);
        end
        clear_all();
        repeat (3) @(negedge clk);
        total++;
        if (wq.size() != nw) begin bad++; $display("FAIL t6 trailing write: got %0d writes want %0d", wq.size(), nw); end
        @(posedge clk);
        #2 reset = 1'b0;
        m_ptr = 0;
        wq.delete(); gq.delete(); acc_log.delete();
        push_byte(3, 8'h63, 1, 1);
        push_byte(0, 8'h60, 1, 1);
        model_expect();
        wait_idle(300, ok);
        total++;
        if (!ok || gq.size() == 0 || gq[0] !== 2'd0) begin
            bad++; $display("FAIL t6 first grant after reset: got %0d want 0 (idle=%b)", (gq.size() > 0) ? gq[0] : 3, ok);
        end
        total++;
        if (wq.size() != exp_d.size()) begin
            bad++; $display("FAIL t6 write count: got %0d want %0d", wq.size(), exp_d.size());
        end
        for (int k = 0; k < wq.size() && k < exp_d.size(); k++) begin
            total++;
            if (wq[k] !== exp_d[k] || gq[k] !== exp_g[k]) begin
                bad++;
                $display("FAIL t6 write %0d: got %h id%0d want %h id%0d", k, wq[k], gq[k], exp_d[k], exp_g[k]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int np, len;
        do_reset();
        for (int round = 0; round < 3; round++) begin
            wq.delete(); gq.delete();
            stall_en = 1;
            for (int i = 0; i < N; i++) begin
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), b == 0, b == len - 1);
                end
            end
            model_expect();
            wait_idle(3000, ok);
            stall_en = 0;
            total++;
            if (!ok) begin bad++; $display("FAIL rnd%0d idle timeout", round); end
            total++;
            if (wq.size() != exp_d.size()) begin
                bad++; $display("FAIL rnd%0d write count: got %0d want %0d", round, wq.size(), exp_d.size());
            end
            for (int k = 0; k < wq.size() && k < exp_d.size(); k++) begin
                total++;
                if (wq[k] !== exp_d[k] || gq[k] !== exp_g[k]) begin
                    bad++;
                    $display("FAIL rnd%0d write %0d: got %h id%0d want %h id%0d",
                             round, k, wq[k], gq[k], exp_d[k], exp_g[k]);
                end
            end
        end
        total++;
        if (proto_err != 0) begin bad++; $display("FAIL protocol violations: got %0d want 0", proto_err); end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_hold();
        test_timeout();
        test_single_byte_tag();
        test_reset_mid_packet();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
